// File: rtl/enc_pkg.sv
// Shared definitions for the priority bit scanner.
// Provides FSM state encodings and a constant-evaluable clog2 helper.
package enc_pkg;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_SCAN = 1'b1;

  // Ceiling log2, usable in parameter expressions; returns 1 for v <= 2
  // so that an index port is never zero bits wide.
  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/prio_enc_n.sv
// Combinational generalised priority encoder.
// Ports: vec (WIDTH) in; idx (IDX_W) index of the winning set bit; any = vec != 0.
module prio_enc_n
  import enc_pkg::*;
#(
  parameter int  WIDTH     = 8,
  parameter int  MSB_FIRST = 1,
  localparam int IDX_W     = clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Scan order is chosen so the winning bit is the last one written:
  // ascending for MSB-first, descending for LSB-first. All-zero gives 0.
  always_comb begin
    idx = '0;
    if (MSB_FIRST != 0) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (vec[i]) idx = IDX_W'(i);
      end
    end else begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (vec[i]) idx = IDX_W'(i);
      end
    end
  end

  assign any = |vec;

endmodule

// File: rtl/priority_bit_scanner.sv
// Latches a request vector over valid/ready and drains its set bits one per beat.
// Ports: clk, rst(async high), in_valid/in_ready/in_vec, out_valid/out_ready/out_idx/out_last/out_none.
module priority_bit_scanner
  import enc_pkg::*;
#(
  parameter int  WIDTH     = 8,
  parameter int  MSB_FIRST = 1,
  localparam int IDX_W     = clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             out_none
);

  logic             state;
  logic             state_nxt;
  logic [WIDTH-1:0] pend;
  logic             none_q;
  logic [IDX_W-1:0] enc_idx;
  logic             enc_any;
  logic             last_c;
  logic             accept;
  logic             pop;
  logic [WIDTH-1:0] one;
  logic [WIDTH-1:0] clr_mask;

  prio_enc_n #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_enc (
    .vec (pend),
    .idx (enc_idx),
    .any (enc_any)
  );

  // At most one bit set: clearing the lowest set bit leaves nothing.
  assign last_c   = (pend & (pend - WIDTH'(1))) == '0;
  assign one      = WIDTH'(1);
  assign clr_mask = ~(one << enc_idx);

  assign accept = in_valid && in_ready;
  assign pop    = out_valid && out_ready;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; a vector taken on the final beat re-enters SCAN.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (accept) state_nxt = ST_SCAN;
      end
      ST_SCAN: begin
        if (pop && out_last) begin
          state_nxt = accept ? ST_SCAN : ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are forced to zero outside SCAN so stale none_q never leaks.
  always_comb begin
    out_valid = 1'b0;
    out_idx   = '0;
    out_last  = 1'b0;
    out_none  = 1'b0;
    in_ready  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
      end
      ST_SCAN: begin
        out_valid = 1'b1;
        out_idx   = enc_any ? enc_idx : '0;
        out_last  = last_c;
        out_none  = none_q;
        in_ready  = out_ready && last_c;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  // Pending vector and all-zero flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend   <= '0;
      none_q <= 1'b0;
    end else if (accept) begin
      pend   <= in_vec;
      none_q <= (in_vec == '0);
    end else if (pop) begin
      pend <= pend & clr_mask;
      if (out_last) none_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_priority_bit_scanner.sv
// Self-checking bench for priority_bit_scanner.
// Directed scenarios plus randomized vectors against a queue-based model.
module tb_priority_bit_scanner;

  logic        clk;
  logic        rst;

  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_vec;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_idx;
  logic        out_last;
  logic        out_none;

  logic        w_in_valid;
  logic        w_in_ready;
  logic [15:0] w_in_vec;
  logic        w_out_valid;
  logic        w_out_ready;
  logic [3:0]  w_out_idx;
  logic        w_out_last;
  logic        w_out_none;

  int tests;
  int fails;

  priority_bit_scanner #(.WIDTH(8), .MSB_FIRST(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vec    (in_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .out_none  (out_none)
  );

  priority_bit_scanner #(.WIDTH(16), .MSB_FIRST(0)) dut16 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (w_in_valid),
    .in_ready  (w_in_ready),
    .in_vec    (w_in_vec),
    .out_valid (w_out_valid),
    .out_ready (w_out_ready),
    .out_idx   (w_out_idx),
    .out_last  (w_out_last),
    .out_none  (w_out_none)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: ordered list of indices a vector should produce.
  function automatic void build(input logic [15:0] v, input int w,
                                input bit msb, output int q[$]);
    q = {};
    if (v == 16'h0) begin
      q.push_back(0);
    end else if (msb) begin
      for (int i = w - 1; i >= 0; i--) if (v[i]) q.push_back(i);
    end else begin
      for (int i = 0; i < w; i++) if (v[i]) q.push_back(i);
    end
  endfunction

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_idx !== 3'd0 ||
        out_last !== 1'b0 || out_none !== 1'b0) begin
      fails++;
      $display("FAIL reset: v=%b r=%b i=%0d l=%b n=%b want 0 1 0 0 0",
               out_valid, in_ready, out_idx, out_last, out_none);
    end
    tests++;
    if (w_out_valid !== 1'b0 || w_in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset16: v=%b r=%b want 0 1", w_out_valid, w_in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int exp_i[3] = '{5, 3, 1};
    @(negedge clk);
    in_valid = 1'b1; in_vec = 8'b00101010; out_ready = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid = 1'b0; in_vec = 8'hFF;
      #1;
      tests++;
      if (out_valid !== 1'b1 || out_idx !== 3'(exp_i[k]) ||
          out_last !== (k == 2) || out_none !== 1'b0) begin
        fails++;
        $display("FAIL basic beat%0d: v=%b i=%0d l=%b n=%b want 1 %0d %b 0",
                 k, out_valid, out_idx, out_last, out_none, exp_i[k], k == 2);
      end
      @(posedge clk);
    end
    @(negedge clk); #1;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL basic idle: v=%b r=%b want 0 1", out_valid, in_ready);
    end
    // all-zero vector: single none beat
    in_valid = 1'b1; in_vec = 8'h00;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; #1;
    tests++;
    if (out_valid !== 1'b1 || out_none !== 1'b1 || out_idx !== 3'd0 ||
        out_last !== 1'b1) begin
      fails++;
      $display("FAIL zero: v=%b n=%b i=%0d l=%b want 1 1 0 1",
               out_valid, out_none, out_idx, out_last);
    end
    @(posedge clk);
    @(negedge clk); #1;
    tests++;
    if (out_valid !== 1'b0 || out_none !== 1'b0) begin
      fails++;
      $display("FAIL zero end: v=%b n=%b want 0 0", out_valid, out_none);
    end
  endtask

  task automatic test_stall();
    @(negedge clk);
    in_valid = 1'b1; in_vec = 8'h81; out_ready = 1'b0;
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid = 1'b0; in_vec = 8'h3C; #1;
      tests++;
      if (out_valid !== 1'b1 || out_idx !== 3'd7 || out_last !== 1'b0) begin
        fails++;
        $display("FAIL stall%0d: v=%b i=%0d l=%b want 1 7 0",
                 k, out_valid, out_idx, out_last);
      end
      @(posedge clk);
    end
    @(negedge clk);
    out_ready = 1'b1; #1;
    tests++;
    if (out_idx !== 3'd7 || out_last !== 1'b0) begin
      fails++;
      $display("FAIL stall rel7: i=%0d l=%b want 7 0", out_idx, out_last);
    end
    @(posedge clk);
    @(negedge clk); #1;
    tests++;
    if (out_valid !== 1'b1 || out_idx !== 3'd0 || out_last !== 1'b1) begin
      fails++;
      $display("FAIL stall rel0: v=%b i=%0d l=%b want 1 0 1",
               out_valid, out_idx, out_last);
    end
    @(posedge clk);
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    in_valid = 1'b1; in_vec = 8'h03; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_vec = 8'h04; #1;
    tests++;
    if (out_idx !== 3'd1 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL b2b beat1: i=%0d r=%b want 1 0", out_idx, in_ready);
    end
    @(posedge clk);
    @(negedge clk); #1;
    tests++;
    if (out_idx !== 3'd0 || out_last !== 1'b1 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL b2b last: i=%0d l=%b r=%b want 0 1 1",
               out_idx, out_last, in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; #1;
    tests++;
    if (out_valid !== 1'b1 || out_idx !== 3'd2 || out_last !== 1'b1) begin
      fails++;
      $display("FAIL b2b next: v=%b i=%0d l=%b want 1 2 1",
               out_valid, out_idx, out_last);
    end
    @(posedge clk);
    @(negedge clk); #1;
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL b2b idle: v=%b want 0", out_valid);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    in_valid = 1'b1; in_vec = 8'hFF; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk); in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk); #1;
    tests++;
    if (out_valid !== 1'b1 || out_idx !== 3'd5) begin
      fails++;
      $display("FAIL rstmid pre: v=%b i=%0d want 1 5", out_valid, out_idx);
    end
    rst = 1'b1; #1;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL rstmid async: v=%b r=%b want 0 1", out_valid, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_vec = 8'h10;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; #1;
    tests++;
    if (out_valid !== 1'b1 || out_idx !== 3'd4 || out_last !== 1'b1) begin
      fails++;
      $display("FAIL rstmid after: v=%b i=%0d l=%b want 1 4 1",
               out_valid, out_idx, out_last);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_wide();
    int q[$];
    int guard;
    logic [15:0] v;
    for (int n = 0; n < 12; n++) begin
      v = (n == 0) ? 16'h8001 : 16'($urandom);
      if (n == 5) v = 16'h0;
      build(v, 16, 1'b0, q);
      @(negedge clk);
      w_in_valid = 1'b1; w_in_vec = v; w_out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      w_in_valid = 1'b0;
      guard = 0;
      while (q.size() > 0 && guard < 40) begin
        #1;
        tests++;
        if (w_out_valid !== 1'b1 || w_out_idx !== 4'(q[0]) ||
            w_out_last !== (q.size() == 1) || w_out_none !== (v == 16'h0)) begin
          fails++;
          $display("FAIL wide v=%h: v=%b i=%0d l=%b n=%b want 1 %0d %b %b",
                   v, w_out_valid, w_out_idx, w_out_last, w_out_none,
                   q[0], q.size() == 1, v == 16'h0);
        end
        void'(q.pop_front());
        @(posedge clk);
        @(negedge clk);
        guard++;
      end
      #1;
      tests++;
      if (w_out_valid !== 1'b0) begin
        fails++;
        $display("FAIL wide end v=%h: valid=%b want 0", v, w_out_valid);
      end
    end
  endtask

  task automatic test_random();
    int q[$];
    int guard;
    logic [7:0] v;
    for (int n = 0; n < 60; n++) begin
      v = 8'($urandom);
      if (n % 7 == 3) v = 8'h00;
      build({8'h0, v}, 8, 1'b1, q);
      @(negedge clk);
      in_valid = 1'b1; in_vec = v; out_ready = 1'b0; #1;
      tests++;
      if (in_ready !== 1'b1) begin
        fails++;
        $display("FAIL rand ready n=%0d: r=%b want 1", n, in_ready);
      end
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0; in_vec = 8'($urandom);
      guard = 0;
      while (q.size() > 0 && guard < 200) begin
        out_ready = 1'($urandom_range(0, 1));
        #1;
        tests++;
        if (out_valid !== 1'b1 || out_idx !== 3'(q[0]) ||
            out_last !== (q.size() == 1) || out_none !== (v == 8'h0)) begin
          fails++;
          $display("FAIL rand v=%h: v=%b i=%0d l=%b n=%b want 1 %0d %b %b",
                   v, out_valid, out_idx, out_last, out_none,
                   q[0], q.size() == 1, v == 8'h0);
        end
        if (out_ready) void'(q.pop_front());
        @(posedge clk);
        @(negedge clk);
        guard++;
      end
      tests++;
      if (guard >= 200) begin
        fails++;
        $display("FAIL rand timeout v=%h: left=%0d want 0", v, q.size());
      end
      #1;
      tests++;
      if (out_valid !== 1'b0) begin
        fails++;
        $display("FAIL rand end v=%h: valid=%b want 0", v, out_valid);
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    in_valid = 1'b0; in_vec = '0; out_ready = 1'b1;
    w_in_valid = 1'b0; w_in_vec = '0; w_out_ready = 1'b1;
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_wide();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
